dmem_responder: RTL



---
 rtl/dmem_responder_if.sv | 24 ++
 rtl/dmem_responder.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/dmem_responder_if.sv
// Load/store port between the MEM stage (master) and the data-memory responder (slave).
// One request in flight; request side is valid/ready, response side is valid/ready.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_ctrl;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_ctrl, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_ctrl, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: byte/half/word loads and stores with alignment, range and ctrl checks.
// Response appears LATENCY edges after accept; requests are refused outside IDLE, response held until rsp_ready.
module dmem_responder #(
  parameter int MEM_WORDS = 256,
  parameter int LATENCY   = 2
) (
  input logic             clk,
  input logic             rst_n,
  dmem_responder_if.slave bus
);

  localparam int         IDX_W      = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) << 2;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic        we;
    logic [2:0]  ctrl;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  req_t        req_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        accept;
  logic        commit;

  logic [31:0] mem [MEM_WORDS];

  // Access decode
  logic             is_byte, is_half, is_word, is_unsigned, ctrl_bad;
  logic             misaligned, out_of_range, acc_err;
  logic [1:0]       lane;
  logic [IDX_W-1:0] idx;
  logic [31:0]      rd_word;
  logic [7:0]       rd_byte;
  logic [15:0]      rd_half;
  logic [31:0]      load_data;
  logic [3:0]       byte_en;
  logic [31:0]      wr_shift;
  logic             wr_en;

  assign bus.req_ready = (state_q == IDLE) && rst_n;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign accept        = bus.req_valid && bus.req_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = WAIT;
          cnt_d   = 4'(LATENCY - 1);
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Unsigned load codes are meaningless for stores, so we=1 with them is rejected.
  always_comb begin
    is_byte     = 1'b0;
    is_half     = 1'b0;
    is_word     = 1'b0;
    is_unsigned = 1'b0;
    ctrl_bad    = 1'b0;
    case (req_q.ctrl)
      3'b000: is_byte = 1'b1;
      3'b001: is_half = 1'b1;
      3'b010: is_word = 1'b1;
      3'b100: begin is_byte = 1'b1; is_unsigned = 1'b1; ctrl_bad = req_q.we; end
      3'b101: begin is_half = 1'b1; is_unsigned = 1'b1; ctrl_bad = req_q.we; end
      default: ctrl_bad = 1'b1;
    endcase
  end

  assign lane         = req_q.addr[1:0];
  assign idx          = req_q.addr[IDX_W+1:2];
  assign misaligned   = (is_half && req_q.addr[0]) || (is_word && (req_q.addr[1:0] != 2'b00));
  assign out_of_range = {1'b0, req_q.addr} >= ADDR_LIMIT;
  assign acc_err      = ctrl_bad || misaligned || out_of_range;

  assign rd_word = mem[idx];
  assign rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    rd_byte = rd_word[7:0];
    case (lane)
      2'd0: rd_byte = rd_word[7:0];
      2'd1: rd_byte = rd_word[15:8];
      2'd2: rd_byte = rd_word[23:16];
      2'd3: rd_byte = rd_word[31:24];
      default: rd_byte = rd_word[7:0];
    endcase
  end

  always_comb begin
    load_data = rd_word;
    if (is_byte) begin
      load_data = is_unsigned ? {24'd0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
    end else if (is_half) begin
      load_data = is_unsigned ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
    end
  end

  always_comb begin
    byte_en = 4'b0000;
    if (is_byte)      byte_en = 4'b0001 << lane;
    else if (is_half) byte_en = 4'b0011 << {lane[1], 1'b0};
    else if (is_word) byte_en = 4'b1111;
  end

  assign wr_shift = req_q.wdata << {lane, 3'b000};
  assign wr_en    = commit && req_q.we && !acc_err;

  // Array is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[idx][8*b +: 8] <= wr_shift[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      req_q   <= '0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        req_q <= '{we: bus.req_we, ctrl: bus.req_ctrl, addr: bus.req_addr, wdata: bus.req_wdata};
      end
      if (commit) begin
        err_q   <= acc_err;
        rdata_q <= (acc_err || req_q.we) ? 32'd0 : load_data;
      end
    end
  end

  property p_rsp_hold;
    @(posedge clk) disable iff (!rst_n)
      (bus.rsp_valid && !bus.rsp_ready) |=>
        (bus.rsp_valid && $stable(bus.rsp_rdata) && $stable(bus.rsp_err));
  endproperty
  a_rsp_hold: assert property (p_rsp_hold);

endmodule
